// File: rtl/id_ex_reg.sv
// ID/EX pipeline register.
// Captures the decoded instruction from Decode and presents it to Execute one
// clock later. Supports stall (hold), flush (bubble insert) and counts the
// bubbles inserted by flush with a saturating 16-bit counter.
// All outputs come straight from flops; there is no input-to-output path.
module id_ex_reg #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,

  // pipeline control
  input  logic                  stallE,
  input  logic                  flushE,

  // Decode-stage inputs
  input  logic                  validD,
  input  logic                  RegWriteD,
  input  logic                  ALUSrcD,
  input  logic                  MemWriteD,
  input  logic                  branchD,
  input  logic                  jumpD,
  input  logic                  jalrD,
  input  logic [3:0]            ALUControlD,
  input  logic [1:0]            ResultSrcD,
  input  logic [2:0]            AddressingControlD,
  input  logic [DATA_WIDTH-1:0] RD1D,
  input  logic [DATA_WIDTH-1:0] RD2D,
  input  logic [DATA_WIDTH-1:0] PCD,
  input  logic [DATA_WIDTH-1:0] PCPlus4D,
  input  logic [DATA_WIDTH-1:0] ImmExtD,
  input  logic [4:0]            Rs1D,
  input  logic [4:0]            Rs2D,
  input  logic [4:0]            RdD,

  // Execute-stage outputs
  output logic                  validE,
  output logic                  RegWriteE,
  output logic                  ALUSrcE,
  output logic                  MemWriteE,
  output logic                  branchE,
  output logic                  jumpE,
  output logic                  jalrE,
  output logic [3:0]            ALUControlE,
  output logic [1:0]            ResultSrcE,
  output logic [2:0]            AddressingControlE,
  output logic [DATA_WIDTH-1:0] RD1E,
  output logic [DATA_WIDTH-1:0] RD2E,
  output logic [DATA_WIDTH-1:0] PCE,
  output logic [DATA_WIDTH-1:0] PCPlus4E,
  output logic [DATA_WIDTH-1:0] ImmExtE,
  output logic [4:0]            Rs1E,
  output logic [4:0]            Rs2E,
  output logic [4:0]            RdE,
  output logic [15:0]           flushCount
);

  // control / valid state
  logic                  r_valid;
  logic                  r_regwrite;
  logic                  r_alusrc;
  logic                  r_memwrite;
  logic                  r_branch;
  logic                  r_jump;
  logic                  r_jalr;
  logic [3:0]            r_aluctrl;
  logic [1:0]            r_resultsrc;
  logic [2:0]            r_addrctrl;
  logic [4:0]            r_rd;

  // data state (not cleared by a flush; only the controls make a bubble)
  logic [DATA_WIDTH-1:0] r_rd1;
  logic [DATA_WIDTH-1:0] r_rd2;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_pcplus4;
  logic [DATA_WIDTH-1:0] r_imm;
  logic [4:0]            r_rs1;
  logic [4:0]            r_rs2;

  logic [15:0]           r_flush_cnt;

  // edge qualifiers
  logic                  w_load;
  logic                  w_cnt_sat;

  // Normal load happens only when neither flush nor stall is asserted.
  always_comb begin
    w_load    = !flushE && !stallE;
    w_cnt_sat = (r_flush_cnt == '1);
  end

  // Control fields: flush clears, stall holds, load takes D gated by validD
  // so an invalid decode slot enters Execute as the same bubble as a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_regwrite  <= 1'b0;
      r_alusrc    <= 1'b0;
      r_memwrite  <= 1'b0;
      r_branch    <= 1'b0;
      r_jump      <= 1'b0;
      r_jalr      <= 1'b0;
      r_aluctrl   <= '0;
      r_resultsrc <= '0;
      r_addrctrl  <= '0;
      r_rd        <= '0;
    end else if (flushE) begin
      r_valid     <= 1'b0;
      r_regwrite  <= 1'b0;
      r_alusrc    <= 1'b0;
      r_memwrite  <= 1'b0;
      r_branch    <= 1'b0;
      r_jump      <= 1'b0;
      r_jalr      <= 1'b0;
      r_aluctrl   <= '0;
      r_resultsrc <= '0;
      r_addrctrl  <= '0;
      r_rd        <= '0;
    end else if (!stallE) begin
      r_valid     <= validD;
      r_regwrite  <= validD & RegWriteD;
      r_alusrc    <= validD & ALUSrcD;
      r_memwrite  <= validD & MemWriteD;
      r_branch    <= validD & branchD;
      r_jump      <= validD & jumpD;
      r_jalr      <= validD & jalrD;
      r_aluctrl   <= validD ? ALUControlD        : '0;
      r_resultsrc <= validD ? ResultSrcD         : '0;
      r_addrctrl  <= validD ? AddressingControlD : '0;
      r_rd        <= validD ? RdD                : '0;
    end
  end

  // Data fields: load on a normal edge, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd1     <= '0;
      r_rd2     <= '0;
      r_pc      <= '0;
      r_pcplus4 <= '0;
      r_imm     <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
    end else if (w_load) begin
      r_rd1     <= RD1D;
      r_rd2     <= RD2D;
      r_pc      <= PCD;
      r_pcplus4 <= PCPlus4D;
      r_imm     <= ImmExtD;
      r_rs1     <= Rs1D;
      r_rs2     <= Rs2D;
    end
  end

  // Saturating count of flush edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_cnt <= '0;
    end else if (flushE && !w_cnt_sat) begin
      r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign validE             = r_valid;
  assign RegWriteE          = r_regwrite;
  assign ALUSrcE            = r_alusrc;
  assign MemWriteE          = r_memwrite;
  assign branchE            = r_branch;
  assign jumpE              = r_jump;
  assign jalrE              = r_jalr;
  assign ALUControlE        = r_aluctrl;
  assign ResultSrcE         = r_resultsrc;
  assign AddressingControlE = r_addrctrl;
  assign RD1E               = r_rd1;
  assign RD2E               = r_rd2;
  assign PCE                = r_pc;
  assign PCPlus4E           = r_pcplus4;
  assign ImmExtE            = r_imm;
  assign Rs1E               = r_rs1;
  assign Rs2E               = r_rs2;
  assign RdE                = r_rd;
  assign flushCount         = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_reg.sv
// Testbench for id_ex_reg: vector table plus directed multi-cycle sequences.
`timescale 1ns/1ps
module tb_id_ex_reg;

  logic        clk;
  logic        rst_n;
  logic        stallE, flushE, validD;
  logic        RegWriteD, ALUSrcD, MemWriteD, branchD, jumpD, jalrD;
  logic [3:0]  ALUControlD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  AddressingControlD;
  logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        validE, RegWriteE, ALUSrcE, MemWriteE, branchE, jumpE, jalrE;
  logic [3:0]  ALUControlE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  AddressingControlE;
  logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [15:0] flushCount;

  int n_pass  = 0;
  int n_total = 0;

  id_ex_reg #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .stallE(stallE), .flushE(flushE), .validD(validD),
    .RegWriteD(RegWriteD), .ALUSrcD(ALUSrcD), .MemWriteD(MemWriteD),
    .branchD(branchD), .jumpD(jumpD), .jalrD(jalrD),
    .ALUControlD(ALUControlD), .ResultSrcD(ResultSrcD),
    .AddressingControlD(AddressingControlD),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .validE(validE), .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE),
    .MemWriteE(MemWriteE), .branchE(branchE), .jumpE(jumpE), .jalrE(jalrE),
    .ALUControlE(ALUControlE), .ResultSrcE(ResultSrcE),
    .AddressingControlE(AddressingControlE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .flushCount(flushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the whole run is about 67k cycles.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ctrl bit order: [5]RegWrite [4]ALUSrc [3]MemWrite [2]branch [1]jump [0]jalr
  typedef struct {
    string       name;
    logic        stall, flush, valid;
    logic [5:0]  ctrl;
    logic [3:0]  aluc;
    logic [1:0]  rsrc;
    logic [2:0]  addr;
    logic [31:0] seed;
    logic [4:0]  rd;
    logic        e_valid;
    logic [5:0]  e_ctrl;
    logic [3:0]  e_aluc;
    logic [1:0]  e_rsrc;
    logic [2:0]  e_addr;
    logic [31:0] e_seed;
    logic [4:0]  e_rd;
    logic [15:0] e_fc;
  } vec_t;

  // Data fields are spread from one seed so every field carries a distinct value.
  function automatic logic [31:0] f_rd2(input logic [31:0] s);  return s ^ 32'hFFFF_0000;  endfunction
  function automatic logic [31:0] f_pc(input logic [31:0] s);   return {s[15:0], s[31:16]}; endfunction
  function automatic logic [31:0] f_pcp4(input logic [31:0] s); return s + 32'd4;          endfunction
  function automatic logic [31:0] f_imm(input logic [31:0] s);  return ~s;                 endfunction

  function automatic vec_t mkv(
    input string n, input logic st, fl, va, input logic [5:0] c, input logic [3:0] a,
    input logic [1:0] r, input logic [2:0] ad, input logic [31:0] s, input logic [4:0] d,
    input logic ev, input logic [5:0] ec, input logic [3:0] ea, input logic [1:0] er,
    input logic [2:0] ead, input logic [31:0] es, input logic [4:0] ed, input logic [15:0] efc);
    vec_t v;
    v.name = n; v.stall = st; v.flush = fl; v.valid = va; v.ctrl = c; v.aluc = a;
    v.rsrc = r; v.addr = ad; v.seed = s; v.rd = d;
    v.e_valid = ev; v.e_ctrl = ec; v.e_aluc = ea; v.e_rsrc = er; v.e_addr = ead;
    v.e_seed = es; v.e_rd = ed; v.e_fc = efc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h required %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    stallE = v.stall; flushE = v.flush; validD = v.valid;
    {RegWriteD, ALUSrcD, MemWriteD, branchD, jumpD, jalrD} = v.ctrl;
    ALUControlD = v.aluc; ResultSrcD = v.rsrc; AddressingControlD = v.addr;
    RD1D = v.seed; RD2D = f_rd2(v.seed); PCD = f_pc(v.seed);
    PCPlus4D = f_pcp4(v.seed); ImmExtD = f_imm(v.seed);
    Rs1D = v.seed[4:0]; Rs2D = v.seed[9:5]; RdD = v.rd;
  endtask

  task automatic check_vec(input vec_t v);
    chk({v.name, ".validE"}, {31'd0, validE}, {31'd0, v.e_valid});
    chk({v.name, ".ctrl"}, {26'd0, RegWriteE, ALUSrcE, MemWriteE, branchE, jumpE, jalrE},
        {26'd0, v.e_ctrl});
    chk({v.name, ".ALUControlE"}, {28'd0, ALUControlE}, {28'd0, v.e_aluc});
    chk({v.name, ".ResultSrcE"}, {30'd0, ResultSrcE}, {30'd0, v.e_rsrc});
    chk({v.name, ".AddressingControlE"}, {29'd0, AddressingControlE}, {29'd0, v.e_addr});
    chk({v.name, ".RD1E"}, RD1E, v.e_seed);
    chk({v.name, ".RD2E"}, RD2E, f_rd2(v.e_seed));
    chk({v.name, ".PCE"}, PCE, f_pc(v.e_seed));
    chk({v.name, ".PCPlus4E"}, PCPlus4E, f_pcp4(v.e_seed));
    chk({v.name, ".ImmExtE"}, ImmExtE, f_imm(v.e_seed));
    chk({v.name, ".Rs1E"}, {27'd0, Rs1E}, {27'd0, v.e_seed[4:0]});
    chk({v.name, ".Rs2E"}, {27'd0, Rs2E}, {27'd0, v.e_seed[9:5]});
    chk({v.name, ".RdE"}, {27'd0, RdE}, {27'd0, v.e_rd});
    chk({v.name, ".flushCount"}, {16'd0, flushCount}, {16'd0, v.e_fc});
  endtask

  task automatic check_zero(input string name);
    chk({name, ".ctrl"}, {25'd0, validE, RegWriteE, ALUSrcE, MemWriteE, branchE, jumpE, jalrE}, '0);
    chk({name, ".fields"}, {20'd0, ALUControlE, ResultSrcE, AddressingControlE, RdE}, '0);
    chk({name, ".RD1E"}, RD1E, '0);
    chk({name, ".RD2E"}, RD2E, '0);
    chk({name, ".PCE"}, PCE, '0);
    chk({name, ".PCPlus4E"}, PCPlus4E, '0);
    chk({name, ".ImmExtE"}, ImmExtE, '0);
    chk({name, ".Rs"}, {22'd0, Rs1E, Rs2E}, '0);
    chk({name, ".flushCount"}, {16'd0, flushCount}, '0);
  endtask

  task automatic rand_inputs();
    validD = 1'b1;
    {RegWriteD, ALUSrcD, MemWriteD, branchD, jumpD, jalrD} = 6'b111111;
    ALUControlD = 4'($urandom_range(1, 15)); ResultSrcD = 2'b11; AddressingControlD = 3'b111;
    RD1D = $urandom | 32'h1; RD2D = $urandom | 32'h1; PCD = $urandom | 32'h1;
    PCPlus4D = $urandom | 32'h1; ImmExtD = $urandom | 32'h1;
    Rs1D = 5'd1; Rs2D = 5'd2; RdD = 5'd3;
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = mkv("pass",      0,0,1, 6'b100000, 4'b0001, 2'b00, 3'b000, 32'h0000_00A5, 5'd7,
                   1, 6'b100000, 4'b0001, 2'b00, 3'b000, 32'h0000_00A5, 5'd7, 16'd0);
    vecs[1]  = mkv("load_all",  0,0,1, 6'b111111, 4'b1010, 2'b10, 3'b101, 32'h89AB_CDEF, 5'd31,
                   1, 6'b111111, 4'b1010, 2'b10, 3'b101, 32'h89AB_CDEF, 5'd31, 16'd0);
    vecs[2]  = mkv("stall",     1,0,1, 6'b010101, 4'b0110, 2'b01, 3'b010, 32'h1357_9BDF, 5'd3,
                   1, 6'b111111, 4'b1010, 2'b10, 3'b101, 32'h89AB_CDEF, 5'd31, 16'd0);
    vecs[3]  = mkv("unstall",   0,0,1, 6'b010101, 4'b0110, 2'b01, 3'b010, 32'h1357_9BDF, 5'd3,
                   1, 6'b010101, 4'b0110, 2'b01, 3'b010, 32'h1357_9BDF, 5'd3, 16'd0);
    vecs[4]  = mkv("flush_over_stall", 1,1,1, 6'b001000, 4'b1111, 2'b11, 3'b111, 32'h0, 5'd9,
                   0, 6'b000000, 4'b0000, 2'b00, 3'b000, 32'h1357_9BDF, 5'd0, 16'd1);
    vecs[5]  = mkv("invalid_decode", 0,0,0, 6'b100010, 4'b0011, 2'b01, 3'b001, 32'hCAFE_F00D, 5'd12,
                   0, 6'b000000, 4'b0000, 2'b00, 3'b000, 32'hCAFE_F00D, 5'd0, 16'd1);
    vecs[6]  = mkv("stall_bubble", 1,0,1, 6'b111111, 4'b1001, 2'b10, 3'b110, 32'h1111_1111, 5'd5,
                   0, 6'b000000, 4'b0000, 2'b00, 3'b000, 32'hCAFE_F00D, 5'd0, 16'd1);
    vecs[7]  = mkv("reload",    0,0,1, 6'b000100, 4'b0101, 2'b00, 3'b100, 32'h0F0F_0F0F, 5'd17,
                   1, 6'b000100, 4'b0101, 2'b00, 3'b100, 32'h0F0F_0F0F, 5'd17, 16'd1);
    vecs[8]  = mkv("flush",     0,1,1, 6'b111111, 4'b0111, 2'b11, 3'b011, 32'h2222_2222, 5'd8,
                   0, 6'b000000, 4'b0000, 2'b00, 3'b000, 32'h0F0F_0F0F, 5'd0, 16'd2);
    vecs[9]  = mkv("flush_invalid", 0,1,0, 6'b101010, 4'b1000, 2'b01, 3'b001, 32'h3333_3333, 5'd4,
                   0, 6'b000000, 4'b0000, 2'b00, 3'b000, 32'h0F0F_0F0F, 5'd0, 16'd3);
    vecs[10] = mkv("reload2",   0,0,1, 6'b000011, 4'b1100, 2'b11, 3'b011, 32'hFFFF_FFFF, 5'd1,
                   1, 6'b000011, 4'b1100, 2'b11, 3'b011, 32'hFFFF_FFFF, 5'd1, 16'd3);

    // reset, then load something non-zero and pulse reset between edges
    rst_n = 1'b0; stallE = 1'b0; flushE = 1'b0;
    rand_inputs();
    step(); step();
    check_zero("reset_initial");
    rst_n = 1'b1;
    step();
    chk("pre_reset.validE", {31'd0, validE}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_zero("reset_async");
    step();
    rst_n = 1'b1;
    stallE = 1'b0; flushE = 1'b0;
    drive(vecs[0]);
    #1 check_zero("reset_released_no_edge");

    // table of single-edge vectors
    foreach (vecs[i]) begin
      drive(vecs[i]);
      step();
      check_vec(vecs[i]);
    end

    // multi-cycle stall: RD2E must hold across three stalled edges
    drive(vecs[0]); RD2D = 32'h1234_5678;
    step();
    chk("stall_seq.load.RD2E", RD2E, 32'h1234_5678);
    stallE = 1'b1; RD2D = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stall_seq.hold%0d.RD2E", k), RD2E, 32'h1234_5678);
    end
    stallE = 1'b0;
    step();
    chk("stall_seq.release.RD2E", RD2E, 32'hDEAD_BEEF);

    // reset asserted mid-stall clears everything; edges under reset are ignored
    stallE = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_zero("reset_mid_stall");
    stallE = 1'b0; flushE = 1'b1;
    rand_inputs();
    step(); step();
    check_zero("reset_held_edges");
    flushE = 1'b0;
    rst_n = 1'b1;
    // first edge after release performs a normal load
    drive(vecs[1]);
    step();
    check_vec(vecs[1]);

    // saturation of the flush counter
    rst_n = 1'b0;
    #1 chk("sat.reset.flushCount", {16'd0, flushCount}, 32'd0);
    step();
    rst_n = 1'b1;
    flushE = 1'b1;
    for (int n = 1; n <= 65537; n++) begin
      step();
      if (n == 1)     chk("sat.edge1", {16'd0, flushCount}, 32'd1);
      if (n == 65534) chk("sat.edge65534", {16'd0, flushCount}, 32'h0000_FFFE);
      if (n == 65535) chk("sat.edge65535", {16'd0, flushCount}, 32'h0000_FFFF);
      if (n == 65537) chk("sat.edge65537", {16'd0, flushCount}, 32'h0000_FFFF);
    end
    chk("sat.validE", {31'd0, validE}, 32'd0);
    flushE = 1'b0;
    drive(vecs[10]);
    step();
    chk("sat.after_load.flushCount", {16'd0, flushCount}, 32'h0000_FFFF);
    chk("sat.after_load.validE", {31'd0, validE}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of data/address fields.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 stallE  in  1  hold: keep all E-stage outputs unchanged.
REQ-005 flushE  in  1  insert bubble into Execute on next edge.
REQ-006 validD  in  1  Decode slot holds a real instruction.
REQ-007 RegWriteD, ALUSrcD, MemWriteD, branchD, jumpD, jalrD  in  1 each  decoded controls.
REQ-008 ALUControlD  in  4  ALU op; ResultSrcD in 2  result select; AddressingControlD in 3  load/store width.
REQ-009 RD1D, RD2D, PCD, PCPlus4D, ImmExtD  in  DATA_WIDTH each  operands, PC values, extended immediate.
REQ-010 Rs1D, Rs2D, RdD  in  5 each  register indices (for forwarding/hazard use).
REQ-011 Every D input has a registered E output of equal width (suffix E), plus validE out 1.
REQ-012 flushCount  out  16  number of bubbles inserted by flushE since reset.

Function
REQ-013 Latency: D inputs appear on E outputs exactly one rising edge later when stallE=0 and flushE=0.
REQ-014 Priority per edge: flushE > stallE > normal load.
REQ-015 Flush (flushE=1, regardless of stallE): validE=0; RegWriteE, MemWriteE, branchE, jumpE, jalrE=0; ALUControlE=0000; ResultSrcE=00; ALUSrcE=0; AddressingControlE=000; RdE=0; data fields may retain previous values.
REQ-016 Stall (stallE=1, flushE=0): all E outputs, including validE, hold previous value.
REQ-017 Normal load with validD=0: load as bubble (same values as REQ-015); flushCount not incremented.
REQ-018 Side-effect gating: whenever validE=0, RegWriteE, MemWriteE, branchE, jumpE, jalrE shall be 0.
REQ-019 flushCount increments by 1 on each edge with flushE=1 and saturates at 16'hFFFF (no wrap).
REQ-020 Bubble state (validE=0, controls cleared) equals a decoded NOP with no architectural effect.
REQ-021 Registered outputs only; no combinational path from any input to any output.

Reset
REQ-022 On rst_n low, immediately (without clock) all E outputs, validE and flushCount go to 0.
REQ-023 While rst_n low, clock edges, stallE and flushE are ignored.
REQ-024 First rising edge after rst_n deassertion performs a normal REQ-014 update.
REQ-025 Reset asserted mid-stall or mid-flush clears state; no held value survives reset.

Verification
REQ-026 Reset: drive random D inputs, pulse rst_n low between edges -> all outputs 0 asynchronously, flushCount=0.
REQ-027 Pass-through: validD=1, RegWriteD=1, ALUControlD=0001, RD1D=32'h0000_00A5, RdD=7, one edge -> RegWriteE=1, ALUControlE=0001, RD1E=32'h0000_00A5, RdE=7, validE=1.
REQ-028 Stall: load RD2D=32'h1234_5678, then stallE=1 for 3 edges with RD2D=32'hDEAD_BEEF -> RD2E stays 32'h1234_5678 all 3 cycles.
REQ-029 Flush over stall: MemWriteD=1, validD=1, stallE=1, flushE=1 -> MemWriteE=0, validE=0, RdE=0, flushCount=1.
REQ-030 Invalid decode: validD=0, RegWriteD=1, jumpD=1 -> RegWriteE=0, jumpE=0, validE=0, flushCount unchanged.
REQ-031 Saturation: flushE=1 for 65,537 edges -> flushCount=16'hFFFF after edge 65,535 and remains so.
